// File: rtl/pipe_sched_pkg.sv
// Shared encodings for the pipeline stall/flush scheduler.
package pipe_sched_pkg;

    // Registered scheduler state, visible on sched_state.
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_STALL  = 2'b01,
        ST_FREEZE = 2'b10
    } sched_state_e;

    localparam int unsigned CTRL_W = 5;

    // Pipeline control bundle, MSB first: {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic pipe_hold;
    } ctrl_t;

    localparam ctrl_t CTRL_ADVANCE = CTRL_W'(5'b11000);
    localparam ctrl_t CTRL_STALL   = CTRL_W'(5'b00010);
    localparam ctrl_t CTRL_FREEZE  = CTRL_W'(5'b00001);
    localparam ctrl_t CTRL_SQUASH  = CTRL_W'(5'b11100);

    // Encoding of the state to return to once a memory freeze ends.
    localparam logic RESUME_RUN   = 1'b0;
    localparam logic RESUME_STALL = 1'b1;

endpackage

// File: rtl/pipe_stall_sched_sat_counter.sv
// Saturating up-counter used for the scheduler statistics.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment unless already at the all-ones ceiling.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stall_sched.sv
// Central stall/bubble/flush scheduler for the 5-stage pipeline.
module pipe_stall_sched
    import pipe_sched_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned BR_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_use_hz,
    input  logic [BR_W-1:0]  br_hz_cycles,
    input  logic             br_taken,
    input  logic             jump,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic [1:0]       sched_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    sched_state_e    state_q;
    sched_state_e    state_d;
    sched_state_e    eval_state_c;
    logic [BR_W-1:0] rem_q;
    logic [BR_W-1:0] rem_d;
    logic            resume_q;
    logic            resume_d;
    logic [BR_W-1:0] need_c;
    logic            mem_wait_c;
    logic            freeze_hold_c;
    logic            mem_stop_c;
    ctrl_t           ctrl_c;
    ctrl_t           ctrl_out_c;

    // Stall cycles requested by the instruction in ID: the larger of load-use (1) and branch operand wait.
    always_comb begin
        need_c = br_hz_cycles;
        if (ld_use_hz && (br_hz_cycles == '0)) begin
            need_c = BR_W'(1);
        end
    end

    // Next-state and Mealy control decode; a released FREEZE re-enters the saved state's rules.
    always_comb begin
        ctrl_c        = CTRL_ADVANCE;
        state_d       = state_q;
        rem_d         = rem_q;
        resume_d      = resume_q;
        mem_wait_c    = dmem_req && !dmem_ready;
        freeze_hold_c = (state_q == ST_FREEZE) && mem_wait_c;
        mem_stop_c    = (state_q != ST_FREEZE) && mem_wait_c;
        eval_state_c  = state_q;
        if (state_q == ST_FREEZE) begin
            eval_state_c = (resume_q == RESUME_STALL) ? ST_STALL : ST_RUN;
        end

        if (freeze_hold_c) begin
            ctrl_c = CTRL_FREEZE;
        end else begin
            case (eval_state_c)
                ST_STALL: begin
                    if (mem_stop_c) begin
                        ctrl_c   = CTRL_FREEZE;
                        state_d  = ST_FREEZE;
                        resume_d = RESUME_STALL;
                    end else begin
                        ctrl_c  = CTRL_STALL;
                        rem_d   = rem_q - BR_W'(1);
                        state_d = (rem_q <= BR_W'(1)) ? ST_RUN : ST_STALL;
                    end
                end
                default: begin
                    if (mem_stop_c) begin
                        ctrl_c   = CTRL_FREEZE;
                        state_d  = ST_FREEZE;
                        resume_d = RESUME_RUN;
                    end else if (need_c != '0) begin
                        ctrl_c  = CTRL_STALL;
                        rem_d   = need_c - BR_W'(1);
                        state_d = (need_c > BR_W'(1)) ? ST_STALL : ST_RUN;
                    end else if (br_taken || jump) begin
                        ctrl_c  = CTRL_SQUASH;
                        state_d = ST_RUN;
                    end else begin
                        ctrl_c  = CTRL_ADVANCE;
                        state_d = ST_RUN;
                    end
                end
            endcase
        end
    end

    // Scheduler state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            rem_q    <= '0;
            resume_q <= RESUME_RUN;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            resume_q <= resume_d;
        end
    end

    // While reset is held the pipeline free-runs regardless of hazard inputs.
    always_comb begin
        ctrl_out_c = ctrl_c;
        if (!rst_n) begin
            ctrl_out_c = CTRL_ADVANCE;
        end
    end

    assign pc_write    = ctrl_out_c.pc_write;
    assign ifid_write  = ctrl_out_c.ifid_write;
    assign ifid_flush  = ctrl_out_c.ifid_flush;
    assign idex_flush  = ctrl_out_c.idex_flush;
    assign pipe_hold   = ctrl_out_c.pipe_hold;
    assign sched_state = rst_n ? state_q : ST_RUN;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!ctrl_out_c.pc_write),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctrl_out_c.ifid_flush || ctrl_out_c.idex_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipe_stall_sched.sv
// Self-checking bench for pipe_stall_sched with a cycle-level behavioural model.
module tb_pipe_stall_sched;

    localparam int unsigned BR_W    = 2;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned CNT_W_S = 4;
    localparam int          MAX16   = 65535;
    localparam int          MAX4    = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic ld_use_hz, br_taken, jump, dmem_req, dmem_ready;
    logic [BR_W-1:0] br_hz_cycles;

    logic pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold;
    logic [1:0] sched_state;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    logic pc_write_s, ifid_write_s, ifid_flush_s, idex_flush_s, pipe_hold_s;
    logic [1:0] sched_state_s;
    logic [CNT_W_S-1:0] stall_cycles_s, flush_count_s;

    int checks = 0;
    int errors = 0;

    // Model: owed stall cycles, memory-freeze flag, unbounded event counts.
    int m_pend, n_pend;
    bit m_frz, n_frz;
    int m_stall, m_flush;
    logic [4:0] e_pat;
    logic [1:0] e_state;

    always #5 clk = ~clk;

    pipe_stall_sched #(.CNT_W(CNT_W), .BR_W(BR_W)) dut (
        .clk(clk), .rst_n(rst_n), .ld_use_hz(ld_use_hz), .br_hz_cycles(br_hz_cycles),
        .br_taken(br_taken), .jump(jump), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .pipe_hold(pipe_hold), .sched_state(sched_state),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipe_stall_sched #(.CNT_W(CNT_W_S), .BR_W(BR_W)) dut_s (
        .clk(clk), .rst_n(rst_n), .ld_use_hz(ld_use_hz), .br_hz_cycles(br_hz_cycles),
        .br_taken(br_taken), .jump(jump), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write_s), .ifid_write(ifid_write_s), .ifid_flush(ifid_flush_s),
        .idex_flush(idex_flush_s), .pipe_hold(pipe_hold_s), .sched_state(sched_state_s),
        .stall_cycles(stall_cycles_s), .flush_count(flush_count_s)
    );

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Expected control for the current inputs, plus the model's next state.
    function automatic void predict();
        int n;
        bit wait_mem;
        wait_mem = dmem_req && !dmem_ready;
        e_state  = m_frz ? 2'd2 : ((m_pend > 0) ? 2'd1 : 2'd0);
        n_pend   = m_pend;
        n_frz    = m_frz;
        if (wait_mem) begin
            e_pat = 5'b00001;
            n_frz = 1'b1;
        end else begin
            n_frz = 1'b0;
            if (m_pend > 0) begin
                e_pat  = 5'b00010;
                n_pend = m_pend - 1;
            end else begin
                n = ld_use_hz ? 1 : 0;
                if (int'(br_hz_cycles) > n) n = int'(br_hz_cycles);
                if (n > 0) begin
                    e_pat  = 5'b00010;
                    n_pend = n - 1;
                end else if (br_taken || jump) begin
                    e_pat = 5'b11100;
                end else begin
                    e_pat = 5'b11000;
                end
            end
        end
    endfunction

    function automatic logic [53:0] exp_all();
        return {e_pat, e_state, e_pat, e_state,
                16'(sat(m_stall, MAX16)), 16'(sat(m_flush, MAX16)),
                4'(sat(m_stall, MAX4)), 4'(sat(m_flush, MAX4))};
    endfunction

    function automatic logic [53:0] obs_all();
        return {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, sched_state,
                pc_write_s, ifid_write_s, ifid_flush_s, idex_flush_s, pipe_hold_s, sched_state_s,
                stall_cycles, flush_count, stall_cycles_s, flush_count_s};
    endfunction

    task automatic set_in(input logic ld, input logic [BR_W-1:0] bh, input logic bt,
                          input logic jp, input logic rq, input logic rd);
        ld_use_hz = ld; br_hz_cycles = bh; br_taken = bt; jump = jp; dmem_req = rq; dmem_ready = rd;
    endtask

    // Advance one clock and commit the model.
    task automatic tick();
        @(posedge clk);
        m_pend = n_pend;
        m_frz  = n_frz;
        if (!e_pat[4]) m_stall++;
        if (e_pat[2] || e_pat[1]) m_flush++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        m_pend = 0; m_frz = 1'b0; m_stall = 0; m_flush = 0;
        n_pend = 0; n_frz = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        checks++;
        if ({pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, sched_state, stall_cycles, flush_count} !==
            {5'b11000, 2'b00, 16'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_forced got=%b/%0d/%0d/%0d exp=11000/0/0/0",
                     {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}, sched_state, stall_cycles, flush_count);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            #2; predict();
            checks++;
            if (obs_all() !== exp_all()) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(i == 0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            #2; predict();
            checks++;
            if (obs_all() !== exp_all()) begin
                errors++;
                $display("FAIL load_use cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            tick();
        end
        checks++;
        if ({stall_cycles, flush_count} !== {16'd1, 16'd1}) begin
            errors++;
            $display("FAIL load_use_counts got=%0d/%0d exp=1/1", stall_cycles, flush_count);
        end
    endtask

    task automatic test_branch_stall();
        logic [1:0] want_state [2];
        want_state[0] = 2'b00; want_state[1] = 2'b01;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, (i < 2) ? 2'd2 : 2'd0, i < 3, 1'b0, 1'b0, 1'b0);
            #2; predict();
            checks++;
            if (obs_all() !== exp_all()) begin
                errors++;
                $display("FAIL branch_stall cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            if (i < 2) begin
                checks++;
                if (sched_state !== want_state[i] || pc_write !== 1'b0 || ifid_flush !== 1'b0) begin
                    errors++;
                    $display("FAIL branch_stall_state cyc=%0d got=%b pcw=%b iff=%b exp=%b pcw=0 iff=0",
                             i, sched_state, pc_write, ifid_flush, want_state[i]);
                end
            end
            tick();
        end
        checks++;
        if ({stall_cycles, flush_count} !== {16'd2, 16'd3}) begin
            errors++;
            $display("FAIL branch_stall_counts got=%0d/%0d exp=2/3", stall_cycles, flush_count);
        end
    endtask

    task automatic test_mem_in_stall();
        int holds = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       set_in(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
                1, 2, 3, 4: set_in(1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
                5:       set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
                default: set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            endcase
            #2; predict();
            if (pipe_hold === 1'b1) holds++;
            checks++;
            if (obs_all() !== exp_all()) begin
                errors++;
                $display("FAIL mem_in_stall cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            tick();
        end
        checks++;
        if (stall_cycles !== 16'd7 || holds != 4) begin
            errors++;
            $display("FAIL mem_in_stall_totals got stall=%0d hold=%0d exp stall=7 hold=4", stall_cycles, holds);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 21; i++) begin
            set_in(i < 20, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            #2; predict();
            checks++;
            if (obs_all() !== exp_all()) begin
                errors++;
                $display("FAIL saturation cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            tick();
        end
        checks++;
        if ({stall_cycles_s, flush_count_s, stall_cycles} !== {4'd15, 4'd15, 16'd20}) begin
            errors++;
            $display("FAIL saturation_counts got=%0d/%0d/%0d exp=15/15/20", stall_cycles_s, flush_count_s, stall_cycles);
        end
    endtask

    task automatic test_async_reset_freeze();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
            #2; predict();
            checks++;
            if (obs_all() !== exp_all()) begin
                errors++;
                $display("FAIL freeze_entry cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            tick();
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, sched_state, stall_cycles, flush_count,
             stall_cycles_s} !== {5'b11000, 2'b00, 16'd0, 16'd0, 4'd0}) begin
            errors++;
            $display("FAIL async_reset got=%b/%0d/%0d/%0d exp=11000/0/0/0",
                     {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}, sched_state, stall_cycles, flush_count);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            set_in(($urandom % 5) == 0,
                   (($urandom % 6) == 0) ? 2'($urandom_range(3, 0)) : 2'd0,
                   ($urandom % 4) == 0, ($urandom % 6) == 0,
                   ($urandom % 3) == 0, ($urandom % 3) == 0);
            #2; predict();
            checks++;
            if (obs_all() !== exp_all()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch_stall();
        test_mem_in_stall();
        test_saturation();
        test_async_reset_freeze();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
